// File: rtl/div_unit_pkg.sv
// Shared definitions for the RV32M divide unit: operation encoding, issue payload
// and FSM state type.
package div_unit_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [1:0] DIV_OP_DIV  = 2'd0;
    localparam logic [1:0] DIV_OP_DIVU = 2'd1;
    localparam logic [1:0] DIV_OP_REM  = 2'd2;
    localparam logic [1:0] DIV_OP_REMU = 2'd3;

    localparam logic [2:0] EXE_PIPE_ID_DIV = 3'd3;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef struct packed {
        logic [1:0]      div_control;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } ix_div_inf_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } div_state_t;

    // DIV and REM are the signed ops; DIV and DIVU return the quotient.
    function automatic logic is_signed_op(input logic [1:0] op);
        return !op[0];
    endfunction

    function automatic logic is_quot_op(input logic [1:0] op);
        return !op[1];
    endfunction

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic c);
        return c ? -v : v;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Issue / write-back / flush signals between the pipeline and the divide unit.
interface div_unit_if;
    import div_unit_pkg::*;

    logic            wb_do_branch;
    logic            ix_div_valid;
    ix_div_inf_t     ix_div_inf;
    logic            div_wb_valid;
    logic            div_wb_ready;
    logic [4:0]      div_wb_rd;
    logic [XLEN-1:0] div_wb_result;
    logic            div_ix_done;
    logic            div_busy;

    modport master (
        output wb_do_branch, ix_div_valid, ix_div_inf, div_wb_ready,
        input  div_wb_valid, div_wb_rd, div_wb_result, div_ix_done, div_busy
    );

    modport slave (
        input  wb_do_branch, ix_div_valid, ix_div_inf, div_wb_ready,
        output div_wb_valid, div_wb_rd, div_wb_result, div_ix_done, div_busy
    );

endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One operation in flight; XLEN CALC cycles plus one FIXUP cycle on the normal path.
module div_unit
    import div_unit_pkg::*;
(
    input logic       clk,
    input logic       rst,
    div_unit_if.slave bus
);

    div_state_t      state;
    logic [1:0]      op;
    logic            rs1_neg;
    logic            rs2_neg;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] divisor;
    logic [CNT_W-1:0] counter;
    logic            valid_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] result_q;

    // Issue-side decode: operand magnitudes and the two short-circuit cases.
    logic [1:0]      op_in;
    logic [XLEN-1:0] rs1_in;
    logic [XLEN-1:0] rs2_in;
    logic            sgn_in;
    logic            rs1_neg_in;
    logic            rs2_neg_in;
    logic [XLEN-1:0] abs1;
    logic [XLEN-1:0] abs2;
    logic            div_by_zero;
    logic            overflow;
    logic [XLEN-1:0] special_result;

    // NOTE: every always_comb output gets a value on every path; a missed
    // assignment would infer a latch.
    always_comb begin
        op_in       = bus.ix_div_inf.div_control;
        rs1_in      = bus.ix_div_inf.rs1;
        rs2_in      = bus.ix_div_inf.rs2;
        sgn_in      = is_signed_op(op_in);
        rs1_neg_in  = sgn_in & rs1_in[XLEN-1];
        rs2_neg_in  = sgn_in & rs2_in[XLEN-1];
        abs1        = neg_if(rs1_in, rs1_neg_in);
        abs2        = neg_if(rs2_in, rs2_neg_in);
        div_by_zero = (rs2_in == '0);
        overflow    = sgn_in && (rs1_in == INT_MIN) && (rs2_in == '1);
        if (div_by_zero)
            special_result = is_quot_op(op_in) ? '1 : rs1_in;
        else
            special_result = (op_in == DIV_OP_DIV) ? INT_MIN : '0;
    end

    // One restoring step. acc < divisor holds throughout, so the shifted
    // partial remainder needs XLEN+1 bits and the trial's top bit is the borrow.
    logic [XLEN:0]   acc_sh;
    logic [XLEN:0]   trial;
    logic            borrow;
    logic [XLEN-1:0] acc_nx;
    logic [XLEN-1:0] quo_nx;

    always_comb begin
        acc_sh = {acc, quo[XLEN-1]};
        trial  = acc_sh - {1'b0, divisor};
        borrow = trial[XLEN];
        acc_nx = borrow ? acc_sh[XLEN-1:0] : trial[XLEN-1:0];
        quo_nx = {quo[XLEN-2:0], ~borrow};
    end

    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    always_comb begin
        quo_fix = neg_if(quo, rs1_neg ^ rs2_neg);
        rem_fix = neg_if(acc, rs1_neg);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op       <= DIV_OP_DIV;
            rs1_neg  <= 1'b0;
            rs2_neg  <= 1'b0;
            acc      <= '0;
            quo      <= '0;
            divisor  <= '0;
            counter  <= '0;
            valid_q  <= 1'b0;
            rd_q     <= '0;
            result_q <= '0;
        end else if (bus.wb_do_branch) begin
            state   <= IDLE;
            valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.ix_div_valid) begin
                        rd_q    <= bus.ix_div_inf.rd;
                        op      <= op_in;
                        rs1_neg <= rs1_neg_in;
                        rs2_neg <= rs2_neg_in;
                        if (div_by_zero || overflow) begin
                            result_q <= special_result;
                            valid_q  <= 1'b1;
                            state    <= DONE;
                        end else begin
                            quo     <= abs1;
                            divisor <= abs2;
                            acc     <= '0;
                            counter <= CNT_W'(XLEN - 1);
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc     <= acc_nx;
                    quo     <= quo_nx;
                    counter <= counter - CNT_W'(1);
                    if (counter == '0)
                        state <= FIXUP;
                end
                FIXUP: begin
                    result_q <= is_quot_op(op) ? quo_fix : rem_fix;
                    valid_q  <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    if (bus.div_wb_ready) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.div_wb_valid  = valid_q;
    assign bus.div_wb_rd     = rd_q;
    assign bus.div_wb_result = result_q;
    assign bus.div_busy      = (state != IDLE);
    assign bus.div_ix_done   = (state == DONE) && bus.div_wb_ready && !bus.wb_do_branch;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed table, flush/reset sequences and
// randomized ops checked against an arithmetic reference model.
module tb_div_unit;
    import div_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    div_unit_if bus();

    div_unit dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        int          hold;
        string       name;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive point: just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: 64-bit arithmetic covers the signed overflow case naturally.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint la, lb, q, r;
        logic   sgn;
        sgn = ~op[0];
        if (b == 32'd0) return (op[1] == 1'b0) ? 32'hFFFF_FFFF : a;
        la = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        lb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        q  = la / lb;
        r  = la % lb;
        return (op[1] == 1'b0) ? q[31:0] : r[31:0];
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 2;
    endfunction

    // Issue one op, wait for the result, hold ready low for 'hold' DONE cycles,
    // then complete the handshake. Starts and ends at a sampling (negedge) point.
    task automatic run_op(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input int hold, input string name);
        int   lat;
        logic early_done;
        step();
        bus.ix_div_inf   = '{div_control: op, rd: rd, rs1: a, rs2: b};
        bus.ix_div_valid = 1'b1;
        bus.div_wb_ready = (hold == 0);
        lat        = 0;
        early_done = 1'b0;
        do begin
            step();
            bus.ix_div_valid = 1'b0;
            lat++;
            @(negedge clk);
            if (!bus.div_wb_valid && bus.div_ix_done) early_done = 1'b1;
        end while (!bus.div_wb_valid && lat < 100);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " early_done"}, 64'(early_done), 64'd0);
        if (!bus.div_wb_valid) return;
        check({name, " result"}, 64'(bus.div_wb_result), 64'(exp));
        check({name, " rd"}, 64'(bus.div_wb_rd), 64'(rd));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                if (i > 0) begin
                    step();
                    @(negedge clk);
                end
                check({name, " hold valid"}, 64'(bus.div_wb_valid), 64'd1);
                check({name, " hold result"}, 64'(bus.div_wb_result), 64'(exp));
                check({name, " hold rd"}, 64'(bus.div_wb_rd), 64'(rd));
                check({name, " hold done"}, 64'(bus.div_ix_done), 64'd0);
            end
            step();
            bus.div_wb_ready = 1'b1;
            @(negedge clk);
        end
        check({name, " done pulse"}, 64'(bus.div_ix_done), 64'd1);
        step();
        bus.div_wb_ready = 1'b0;
        @(negedge clk);
        check({name, " post valid"}, 64'(bus.div_wb_valid), 64'd0);
        check({name, " post done"}, 64'(bus.div_ix_done), 64'd0);
        check({name, " post busy"}, 64'(bus.div_busy), 64'd0);
    endtask

    // Issuing while busy is a protocol violation by the bench itself.
    always @(negedge clk) begin
        if (!rst && bus.ix_div_valid && bus.div_busy) begin
            errors++;
            $display("FAIL protocol: ix_div_valid while busy at %0t", $time);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        int          mode;

        rst              = 1'b1;
        bus.wb_do_branch = 1'b0;
        bus.ix_div_valid = 1'b0;
        bus.div_wb_ready = 1'b0;
        bus.ix_div_inf   = '0;
        step();
        step();
        @(negedge clk);
        check("reset valid", 64'(bus.div_wb_valid), 64'd0);
        check("reset done", 64'(bus.div_ix_done), 64'd0);
        check("reset busy", 64'(bus.div_busy), 64'd0);
        check("reset rd", 64'(bus.div_wb_rd), 64'd0);
        check("reset result", 64'(bus.div_wb_result), 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);

        vecs[0] = '{DIV_OP_DIVU, 32'd100,         32'd7,         32'd14,         34, 0, "divu_100_7"};
        vecs[1] = '{DIV_OP_REMU, 32'd100,         32'd7,         32'd2,          34, 0, "remu_100_7"};
        vecs[2] = '{DIV_OP_DIV,  32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFD,  34, 0, "div_m7_2"};
        vecs[3] = '{DIV_OP_REM,  32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFF,  34, 0, "rem_m7_2"};
        vecs[4] = '{DIV_OP_REM,  32'd7,           32'hFFFF_FFFE, 32'd1,          34, 0, "rem_7_m2"};
        vecs[5] = '{DIV_OP_DIV,  32'd5,           32'd0,         32'hFFFF_FFFF,  1,  0, "div_5_0"};
        vecs[6] = '{DIV_OP_REMU, 32'd5,           32'd0,         32'd5,          1,  0, "remu_5_0"};
        vecs[7] = '{DIV_OP_DIV,  32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000,  1,  0, "div_ovf"};
        vecs[8] = '{DIV_OP_REM,  32'h8000_0000,   32'hFFFF_FFFF, 32'd0,          1,  0, "rem_ovf"};
        vecs[9] = '{DIV_OP_DIVU, 32'hFFFF_FFFF,   32'd1,         32'hFFFF_FFFF,  34, 5, "divu_max_hold"};

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].op, 5'(i + 1), vecs[i].a, vecs[i].b, vecs[i].exp,
                   vecs[i].lat, vecs[i].hold, vecs[i].name);

        // Flush in CALC cycle 10, then a fresh op.
        step();
        bus.ix_div_inf   = '{div_control: DIV_OP_DIVU, rd: 5'd7, rs1: 32'd1000, rs2: 32'd3};
        bus.ix_div_valid = 1'b1;
        bus.div_wb_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            bus.ix_div_valid = 1'b0;
            if (i == 10) bus.wb_do_branch = 1'b1;
            @(negedge clk);
            check("calc busy", 64'(bus.div_busy), 64'd1);
            check("calc valid", 64'(bus.div_wb_valid), 64'd0);
        end
        check("flush calc done", 64'(bus.div_ix_done), 64'd0);
        step();
        bus.wb_do_branch = 1'b0;
        bus.div_wb_ready = 1'b0;
        @(negedge clk);
        check("flush calc busy", 64'(bus.div_busy), 64'd0);
        check("flush calc valid", 64'(bus.div_wb_valid), 64'd0);
        check("flush calc done2", 64'(bus.div_ix_done), 64'd0);
        run_op(DIV_OP_DIVU, 5'd8, 32'd9, 32'd3, 32'd3, 34, 0, "divu_9_3_after_flush");

        // Flush coinciding with the write-back handshake: flush wins.
        step();
        bus.ix_div_inf   = '{div_control: DIV_OP_DIV, rd: 5'd11, rs1: 32'd5, rs2: 32'd0};
        bus.ix_div_valid = 1'b1;
        step();
        bus.ix_div_valid = 1'b0;
        @(negedge clk);
        check("flush_hs valid", 64'(bus.div_wb_valid), 64'd1);
        step();
        bus.div_wb_ready = 1'b1;
        bus.wb_do_branch = 1'b1;
        @(negedge clk);
        check("flush_hs done", 64'(bus.div_ix_done), 64'd0);
        step();
        bus.div_wb_ready = 1'b0;
        bus.wb_do_branch = 1'b0;
        @(negedge clk);
        check("flush_hs post valid", 64'(bus.div_wb_valid), 64'd0);
        check("flush_hs post busy", 64'(bus.div_busy), 64'd0);

        // Reset mid-CALC clears everything, then a normal op completes.
        step();
        bus.ix_div_inf   = '{div_control: DIV_OP_DIVU, rd: 5'd9, rs1: 32'd12345, rs2: 32'd17};
        bus.ix_div_valid = 1'b1;
        bus.div_wb_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            bus.ix_div_valid = 1'b0;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.div_wb_ready = 1'b0;
        @(negedge clk);
        check("rst_calc valid", 64'(bus.div_wb_valid), 64'd0);
        check("rst_calc busy", 64'(bus.div_busy), 64'd0);
        check("rst_calc done", 64'(bus.div_ix_done), 64'd0);
        check("rst_calc rd", 64'(bus.div_wb_rd), 64'd0);
        check("rst_calc result", 64'(bus.div_wb_result), 64'd0);
        run_op(DIV_OP_REMU, 5'd10, 32'd12345, 32'd17, ref_result(DIV_OP_REMU, 32'd12345, 32'd17),
               34, 0, "remu_after_rst");

        // Randomized ops against the reference model.
        for (int n = 0; n < 40; n++) begin
            op   = 2'($urandom_range(0, 3));
            a    = $urandom;
            mode = $urandom_range(0, 9);
            case (mode)
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 15);
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom;
            endcase
            run_op(op, 5'($urandom_range(0, 31)), a, b, ref_result(op, a, b),
                   ref_latency(op, a, b), $urandom_range(0, 2), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
